// File: rtl/qspi_fifo_pkg.sv
// qspi_fifo_pkg
// Shared definitions for the QSPI data-path FIFO: default level/threshold
// width and the pointer-width helper used by qspi_fifo_sync and qspi_fifo_mem.
// No ports.
package qspi_fifo_pkg;

  localparam int LVL_W_DEF = 9;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/qspi_fifo_mem.sv
// qspi_fifo_mem
// Simple dual-port RAM, one write port and one read port. The storage array
// is never reset. REG_RD=1 gives a registered read (rdata updates on the edge
// that samples re and holds otherwise; the output register is reset to 0).
// REG_RD=0 gives a combinational read of mem[raddr].
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   async active-low reset (registered read output only)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable (registered read only)
//   raddr  in   read address
//   rdata  out  read data
module qspi_fifo_mem #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter bit REG_RD = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (REG_RD) begin : g_reg_rd
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
      end
    end else begin : g_comb_rd
      // re and rst_n have no role in the fall-through read path.
      logic unused_rd_ctl;
      assign unused_rd_ctl = &{1'b0, re, rst_n};
      assign rdata = mem[raddr];
    end
  endgenerate

endmodule

// File: rtl/qspi_fifo_sync.sv
// qspi_fifo_sync
// Parametrised synchronous FIFO shared by the QSPI TX and RX data paths,
// between the register/DMA front end and the shift engine. Provides
// occupancy level, full/empty, programmable almost-full/almost-empty,
// synchronous flush and sticky overflow/underflow flags.
// Optional feature: define QSPI_FIFO_FWFT_EN for first-word fall-through
// (rd_data_o shows the head word combinationally, rd_en_i acts as a pop).
// Default build is a registered read with one cycle of latency.
// Ports:
//   clk            in   clock, rising edge
//   resetn         in   async active-low reset
//   wr_en_i        in   write request
//   wr_data_i      in   write data
//   rd_en_i        in   read request / pop
//   rd_data_o      out  read data
//   flush_i        in   synchronous flush (priority over wr/rd)
//   af_th_i        in   almost-full threshold
//   ae_th_i        in   almost-empty threshold
//   err_clr_i      in   clears sticky error flags
//   full_o         out  level == DEPTH
//   empty_o        out  level == 0
//   almost_full_o  out  level >= af_th_i
//   almost_empty_o out  level <= ae_th_i
//   level_o        out  occupancy 0..DEPTH
//   overflow_o     out  sticky: write rejected while full
//   underflow_o    out  sticky: read rejected while empty
module qspi_fifo_sync
  import qspi_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int LVL_W = LVL_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  input  logic             flush_i,
  input  logic [LVL_W-1:0] af_th_i,
  input  logic [LVL_W-1:0] ae_th_i,
  input  logic             err_clr_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [LVL_W-1:0] level_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int AW = ptr_w(DEPTH);
`ifdef QSPI_FIFO_FWFT_EN
  localparam bit REG_RD = 1'b0;
`else
  localparam bit REG_RD = 1'b1;
`endif

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             ovf_q, udf_q;
  logic             rd_acc, wr_acc, ovf_set, udf_set;
  logic [WIDTH-1:0] mem_rdata;

  assign full_o         = (level_q == LVL_W'(DEPTH));
  assign empty_o        = (level_q == '0);
  assign almost_full_o  = (level_q >= af_th_i);
  assign almost_empty_o = (level_q <= ae_th_i);
  assign level_o        = level_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

  // Flush masks everything in its cycle, including error detection.
  // A write to a full FIFO is still accepted when a read frees a slot.
  assign rd_acc  = rd_en_i & ~empty_o & ~flush_i;
  assign wr_acc  = wr_en_i & (~full_o | rd_acc) & ~flush_i;
  assign ovf_set = wr_en_i & full_o & ~rd_acc & ~flush_i;
  assign udf_set = rd_en_i & empty_o & ~flush_i;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + {{(LVL_W-1){1'b0}}, wr_acc}
                         - {{(LVL_W-1){1'b0}}, rd_acc};
    end
  end

  // A new error in the clear cycle wins over the clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_set | (ovf_q & ~err_clr_i);
      udf_q <= udf_set | (udf_q & ~err_clr_i);
    end
  end

  qspi_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW),
    .REG_RD(REG_RD)
  ) u_mem (
    .clk  (clk),
    .rst_n(resetn),
    .we   (wr_acc),
    .waddr(wr_ptr_q),
    .wdata(wr_data_i),
    .re   (rd_acc),
    .raddr(rd_ptr_q),
    .rdata(mem_rdata)
  );

`ifdef QSPI_FIFO_FWFT_EN
  assign rd_data_o = empty_o ? '0 : mem_rdata;
`else
  assign rd_data_o = mem_rdata;
`endif

endmodule

// File: tb/tb_qspi_fifo_sync.sv
module tb_qspi_fifo_sync;
  import qspi_fifo_pkg::*;

  localparam int W  = 32;
  localparam int LW = 9;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  logic          we4 = 0, re4 = 0, fl4 = 0, ec4 = 0;
  logic [W-1:0]  wd4 = '0, rd4;
  logic [LW-1:0] af4 = 9'd3, ae4 = 9'd1, lvl4;
  logic          full4, empty4, afo4, aeo4, ovf4, udf4;

  logic          we16 = 0, re16 = 0, fl16 = 0, ec16 = 0;
  logic [W-1:0]  wd16 = '0, rd16;
  logic [LW-1:0] af16 = 9'd12, ae16 = 9'd2, lvl16;
  logic          full16, empty16, afo16, aeo16, ovf16, udf16;

  qspi_fifo_sync #(.WIDTH(W), .DEPTH(4), .LVL_W(LW)) u_dut4 (
    .clk(clk), .resetn(resetn), .wr_en_i(we4), .wr_data_i(wd4),
    .rd_en_i(re4), .rd_data_o(rd4), .flush_i(fl4), .af_th_i(af4),
    .ae_th_i(ae4), .err_clr_i(ec4), .full_o(full4), .empty_o(empty4),
    .almost_full_o(afo4), .almost_empty_o(aeo4), .level_o(lvl4),
    .overflow_o(ovf4), .underflow_o(udf4));

  qspi_fifo_sync #(.WIDTH(W), .DEPTH(16), .LVL_W(LW)) u_dut16 (
    .clk(clk), .resetn(resetn), .wr_en_i(we16), .wr_data_i(wd16),
    .rd_en_i(re16), .rd_data_o(rd16), .flush_i(fl16), .af_th_i(af16),
    .ae_th_i(ae16), .err_clr_i(ec16), .full_o(full16), .empty_o(empty16),
    .almost_full_o(afo16), .almost_empty_o(aeo16), .level_o(lvl16),
    .overflow_o(ovf16), .underflow_o(udf16));

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] q4[$];
  logic [W-1:0] q16[$];
  logic [W-1:0] last4 = '0, last16 = '0;
  logic         m_ovf4 = 0, m_udf4 = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic check4();
    int n;
    n = q4.size();
    chk("level4", lvl4, n);
    chk("full4", full4, n == 4);
    chk("empty4", empty4, n == 0);
    chk("afull4", afo4, n >= int'(af4));
    chk("aempty4", aeo4, n <= int'(ae4));
    chk("ovf4", ovf4, m_ovf4);
    chk("udf4", udf4, m_udf4);
`ifdef QSPI_FIFO_FWFT_EN
    chk("rdata4", rd4, (n > 0) ? q4[0] : '0);
`else
    chk("rdata4", rd4, last4);
`endif
  endtask

  task automatic cyc4(input logic we, input logic [W-1:0] wd, input logic re,
                      input logic fl, input logic ec);
    logic rd_ok, wr_ok, ovf_set, udf_set;
    @(negedge clk);
    we4 = we; wd4 = wd; re4 = re; fl4 = fl; ec4 = ec;
    rd_ok   = re && !fl && q4.size() > 0;
    wr_ok   = we && !fl && (q4.size() < 4 || rd_ok);
    ovf_set = we && !fl && q4.size() == 4 && !rd_ok;
    udf_set = re && !fl && q4.size() == 0;
`ifdef QSPI_FIFO_FWFT_EN
    if (rd_ok) chk("fwft_head4", rd4, q4[0]);
`endif
    @(posedge clk);
    #1;
    if (fl) q4.delete();
    else begin
      if (rd_ok) last4 = q4.pop_front();
      if (wr_ok) q4.push_back(wd);
    end
    m_ovf4 = ovf_set | (m_ovf4 & !ec);
    m_udf4 = udf_set | (m_udf4 & !ec);
    check4();
    we4 = 0; re4 = 0; fl4 = 0; ec4 = 0;
  endtask

  task automatic cyc16(input logic we, input logic [W-1:0] wd, input logic re, input logic fl);
    logic rd_ok, wr_ok;
    int n;
    @(negedge clk);
    we16 = we; wd16 = wd; re16 = re; fl16 = fl;
    rd_ok = re && !fl && q16.size() > 0;
    wr_ok = we && !fl && (q16.size() < 16 || rd_ok);
`ifdef QSPI_FIFO_FWFT_EN
    if (rd_ok) chk("fwft_head16", rd16, q16[0]);
`endif
    @(posedge clk);
    #1;
    if (fl) q16.delete();
    else begin
      if (rd_ok) last16 = q16.pop_front();
      if (wr_ok) q16.push_back(wd);
    end
    n = q16.size();
    chk("level16", lvl16, n);
    chk("empty16", empty16, n == 0);
    chk("afull16", afo16, n >= 12);
    chk("aempty16", aeo16, n <= 2);
    chk("ovf16", ovf16, 1'b0);
`ifdef QSPI_FIFO_FWFT_EN
    chk("rdata16", rd16, (n > 0) ? q16[0] : '0);
`else
    chk("rdata16", rd16, last16);
`endif
    we16 = 0; re16 = 0; fl16 = 0;
  endtask

  initial begin
    #1 resetn = 1'b0;
    #3;
    check4();
    chk("rst_rd16", rd16, 0);
    chk("rst_empty16", empty16, 1'b1);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Fill to full, then drain in order.
    for (int i = 0; i < 4; i++) cyc4(1, W'(i), 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc4(0, '0, 1, 0, 0);
    cyc4(0, '0, 0, 0, 0);

    // Overflow: dropped word never appears.
    for (int i = 0; i < 4; i++) cyc4(1, W'(i), 0, 0, 0);
    cyc4(1, 32'hDEAD, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc4(0, '0, 1, 0, 0);

    // Underflow, clear, and error-vs-clear priority.
    cyc4(0, '0, 1, 0, 0);
    cyc4(0, '0, 0, 0, 1);
    cyc4(0, '0, 1, 0, 1);
    cyc4(0, '0, 0, 0, 1);

    // Simultaneous read+write while full, pointers wrap twice.
    for (int i = 0; i < 4; i++) cyc4(1, 32'h10 + W'(i), 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc4(1, 32'h20 + W'(i), 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc4(0, '0, 1, 0, 0);

    // Flush wins over a same-cycle write and read.
    for (int i = 0; i < 3; i++) cyc4(1, 32'h30 + W'(i), 0, 0, 0);
    cyc4(1, 32'hBAD, 1, 1, 0);
    cyc4(1, 32'h55, 0, 0, 0);
    cyc4(0, '0, 1, 0, 0);
    cyc4(0, '0, 0, 0, 0);

    // Thresholds on the 16-deep FIFO, then flush at level 5.
    for (int i = 0; i < 13; i++) cyc16(1, 32'h100 + W'(i), 0, 0);
    for (int i = 0; i < 8; i++) cyc16(0, '0, 1, 0);
    cyc16(1, 32'h99, 0, 1);
    cyc16(1, 32'h77, 0, 0);
    cyc16(0, '0, 1, 0);
    cyc16(0, '0, 0, 0);

    // Reset mid-operation discards contents and clears flags.
    cyc4(1, 32'hA1, 0, 0, 0);
    cyc4(1, 32'hA2, 0, 0, 0);
    cyc4(1, 32'hA3, 0, 0, 0);
    cyc4(0, '0, 1, 0, 0);
    cyc4(0, '0, 1, 0, 0);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    q4.delete();
    last4 = '0; m_ovf4 = 0; m_udf4 = 0;
    check4();
    @(negedge clk);
    resetn = 1'b1;

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++)
      cyc4(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/qspi_fifo_sync.md
Name: qspi_fifo_sync

Overview:
Parametrised synchronous FIFO for the QSPI controller data paths, the successor to fifo_tx, so that TX and RX buffering share one block.
Adds:
- generic WIDTH/DEPTH with derived pointer width
- programmable almost-full/almost-empty thresholds
- synchronous flush
- sticky overflow/underflow error flags
Sits between the register/DMA front end and the QSPI shift engine.

Parameters:
WIDTH, 32, data word width in bits (1..64)
DEPTH, 16, number of entries; power of two, 2..256
LVL_W, 9, width of level_o and threshold ports; must be >= clog2(DEPTH)+1

Ports:
clk  in  1  system clock, all logic rising-edge
resetn  in  1  asynchronous active-low reset
wr_en_i  in  1  write request
wr_data_i  in  WIDTH  write data
rd_en_i  in  1  read request
rd_data_o  out  WIDTH  read data
flush_i  in  1  synchronous flush, empties FIFO
af_th_i  in  LVL_W  almost-full threshold
ae_th_i  in  LVL_W  almost-empty threshold
err_clr_i  in  1  clears sticky error flags
full_o  out  1  level == DEPTH
empty_o  out  1  level == 0
almost_full_o  out  1  level >= af_th_i
almost_empty_o  out  1  level <= ae_th_i
level_o  out  LVL_W  current occupancy 0..DEPTH
overflow_o  out  1  sticky: write attempted while full and not reading
underflow_o  out  1  sticky: read attempted while empty

Behaviour:
Reset (resetn low, asynchronous assertion):
- pointers and level = 0
- rd_data_o = 0, empty_o = 1, full_o = 0
- overflow_o = underflow_o = 0
- almost_* flags follow their combinational definitions
- reset mid-operation discards all contents
Storage and pointers:
- storage is a DEPTH x WIDTH array, not reset
- wr_ptr/rd_ptr are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0
Accepted write (wr_en_i & (!full | rd_acc)): stores at wr_ptr; wr_ptr+1.
Accepted read (rd_en_i & !empty), i.e. rd_acc:
- rd_data_o <= mem[rd_ptr] on the same edge; rd_ptr+1
- 1-cycle latency: data valid after the edge that samples rd_en_i
- rd_data_o holds its value when no read is accepted
Level update: level_o += acc_wr - acc_rd.
Status flags:
- full_o, empty_o, almost_* derive from the registered level, combinationally
Simultaneous read + write:
- when full: both accepted, level unchanged
- when empty: write accepted, read rejected, underflow_o set
Error flags:
- write rejected when full -> overflow_o = 1; data dropped, state unchanged
- read rejected when empty -> underflow_o = 1; rd_data_o unchanged
- both flags are sticky until err_clr_i
- err_clr_i in the same cycle as a new error: the error wins, flag stays 1
Flush:
- flush_i has priority over wr/rd in its cycle: pointers and level = 0, same-cycle wr/rd ignored
- rd_data_o unchanged; error flags unchanged
Thresholds:
- af_th_i = 0 -> almost_full_o constantly 1
- ae_th_i >= DEPTH -> almost_empty_o constantly 1

Optional Feature:
Macro QSPI_FIFO_FWFT_EN.
- Defined: first-word fall-through.
  - rd_data_o = mem[rd_ptr] combinationally whenever !empty_o (0 when empty)
  - rd_en_i acts as a pop acknowledgement
  - zero-latency read; all flag/level/error rules unchanged
- Undefined: registered read exactly as in Behaviour.

Decomposition:
Shared package qspi_fifo_pkg:
- clog2-derived pointer width function
- LVL_W default constant
One sub-module, qspi_fifo_mem:
- simple dual-port RAM, one write port and one read port
- registered or combinational read selected by parameter
Control, pointers, flags and errors stay in qspi_fifo_sync.

Test Plan:
- WIDTH=32, DEPTH=4: write 0..3 -> full_o=1, level_o=4. Read 4 times -> rd_data_o 0,1,2,3 each one edge after rd_en_i. Then empty_o=1.
- Full FIFO: wr_en_i=1 with rd_en_i=0, data 0xDEAD -> overflow_o=1, level_o stays 4. Subsequent reads return 0..3, never 0xDEAD.
- Empty FIFO: rd_en_i=1 -> underflow_o=1, rd_data_o unchanged. Pulse err_clr_i -> both error flags 0.
- Full FIFO: wr_en_i=rd_en_i=1 for 8 cycles -> level_o stays 4, no overflow_o. Pointers wrap twice and output order is preserved.
- DEPTH=16, af_th_i=12, ae_th_i=2, write 13 words -> almost_full_o rises at level 12, almost_empty_o falls at level 3.
- Level 5, flush_i=1 with wr_en_i=1 -> next cycle level_o=0, empty_o=1, written word discarded. Re-run all scenarios with QSPI_FIFO_FWFT_EN defined: data is visible before rd_en_i.
